// File: rtl/fwd_hazard_unit.sv
// Forwarding / load-use interlock unit for the MIPS pipeline.
// A shift register tracks in-flight destinations: slot 0 is EXE and slot FWD_DEPTH is the
// oldest result-producing stage. ID sources are checked against slots 0..FWD_DEPTH-1 to decide
// load-use stalls, and EXE sources are checked against slots 1..FWD_DEPTH to pick the operand.
module fwd_hazard_unit #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              pipe_en,
  input  logic                              flush,
  input  logic                              id_valid,
  input  logic [REG_AW-1:0]                 id_rs_addr,
  input  logic [REG_AW-1:0]                 id_rt_addr,
  input  logic                              id_rs_used,
  input  logic                              id_rt_used,
  input  logic                              id_wen,
  input  logic [REG_AW-1:0]                 id_waddr,
  input  logic                              id_is_load,
  input  logic [DATA_W-1:0]                 exe_rs_data,
  input  logic [DATA_W-1:0]                 exe_rt_data,
  input  logic [FWD_DEPTH*DATA_W-1:0]       slot_data,
  output logic                              stall,
  output logic [$clog2(FWD_DEPTH+1)-1:0]    fwd_a_sel,
  output logic [$clog2(FWD_DEPTH+1)-1:0]    fwd_b_sel,
  output logic [DATA_W-1:0]                 exe_opa,
  output logic [DATA_W-1:0]                 exe_opb,
  output logic [31:0]                       stall_cnt,
  output logic                              hazard_err
);

  localparam int SEL_W = $clog2(FWD_DEPTH+1);

  logic [FWD_DEPTH:0] s_valid;
  logic [FWD_DEPTH:0] s_wen;
  logic [FWD_DEPTH:0] s_load;
  logic [REG_AW-1:0]  s_waddr [0:FWD_DEPTH];
  logic [REG_AW-1:0]  s0_rs;
  logic [REG_AW-1:0]  s0_rt;
  logic               s0_rs_used;
  logic               s0_rt_used;

  logic rs_hit, rt_hit, rs_stall, rt_stall;
  logic a_hit, b_hit, a_bad, b_bad;
  logic issue;

  // Load-use check: the youngest matching producer decides; it stalls only if it would still be
  // an unready load one slot further down when the consumer reaches EXE.
  always_comb begin
    rs_hit   = 1'b0;
    rt_hit   = 1'b0;
    rs_stall = 1'b0;
    rt_stall = 1'b0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      if (!rs_hit && s_valid[k] && s_wen[k] && s_waddr[k] == id_rs_addr) begin
        rs_hit   = 1'b1;
        rs_stall = s_load[k] && (k + 1 < 1 + LOAD_LAT);
      end
      if (!rt_hit && s_valid[k] && s_wen[k] && s_waddr[k] == id_rt_addr) begin
        rt_hit   = 1'b1;
        rt_stall = s_load[k] && (k + 1 < 1 + LOAD_LAT);
      end
    end
    stall = id_valid && !flush &&
            ((id_rs_used && id_rs_addr != '0 && rs_stall) ||
             (id_rt_used && id_rt_addr != '0 && rt_stall));
    issue = id_valid && !stall && !flush;
  end

  // Operand select for EXE: youngest producer in slots 1..FWD_DEPTH wins, register 0 never forwards.
  always_comb begin
    a_hit     = 1'b0;
    b_hit     = 1'b0;
    a_bad     = 1'b0;
    b_bad     = 1'b0;
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    exe_opa   = exe_rs_data;
    exe_opb   = exe_rt_data;
    for (int j = 1; j <= FWD_DEPTH; j++) begin
      if (!a_hit && s0_rs_used && s0_rs != '0 && s_valid[j] && s_wen[j] && s_waddr[j] == s0_rs) begin
        a_hit     = 1'b1;
        fwd_a_sel = SEL_W'(j);
        exe_opa   = slot_data[(j-1)*DATA_W +: DATA_W];
        a_bad     = s_load[j] && (j < 1 + LOAD_LAT);
      end
      if (!b_hit && s0_rt_used && s0_rt != '0 && s_valid[j] && s_wen[j] && s_waddr[j] == s0_rt) begin
        b_hit     = 1'b1;
        fwd_b_sel = SEL_W'(j);
        exe_opb   = slot_data[(j-1)*DATA_W +: DATA_W];
        b_bad     = s_load[j] && (j < 1 + LOAD_LAT);
      end
    end
  end

  // Slot shift register, stall counter and sticky hazard flag; a frozen pipeline holds everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_valid    <= '0;
      s_wen      <= '0;
      s_load     <= '0;
      for (int j = 0; j <= FWD_DEPTH; j++) s_waddr[j] <= '0;
      s0_rs      <= '0;
      s0_rt      <= '0;
      s0_rs_used <= 1'b0;
      s0_rt_used <= 1'b0;
      stall_cnt  <= '0;
      hazard_err <= 1'b0;
    end else begin
      if (a_bad || b_bad) hazard_err <= 1'b1;
      if (pipe_en) begin
        for (int j = FWD_DEPTH; j >= 1; j--) begin
          s_valid[j] <= s_valid[j-1];
          s_wen[j]   <= s_wen[j-1];
          s_load[j]  <= s_load[j-1];
          s_waddr[j] <= s_waddr[j-1];
        end
        if (flush) s_valid[1] <= 1'b0;
        s_valid[0]  <= issue;
        s_wen[0]    <= issue && id_wen;
        s_load[0]   <= issue && id_is_load;
        s_waddr[0]  <= issue ? id_waddr : '0;
        s0_rs       <= issue ? id_rs_addr : '0;
        s0_rt       <= issue ? id_rt_addr : '0;
        s0_rs_used  <= issue && id_rs_used;
        s0_rt_used  <= issue && id_rt_used;
        if (stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: one instance with LOAD_LAT=1 and one with LOAD_LAT=2
// share the same ID stimulus; each scenario resets both and checks the instance it targets.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n, pipe_en, flush, id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_waddr;
  logic        id_rs_used, id_rt_used, id_wen, id_is_load;
  logic [31:0] exe_rs_data, exe_rt_data;
  logic [95:0] slot_data;

  logic        l1_stall, l2_stall, l1_err, l2_err;
  logic [1:0]  l1_asel, l1_bsel, l2_asel, l2_bsel;
  logic [31:0] l1_opa, l1_opb, l2_opa, l2_opb, l1_cnt, l2_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .FWD_DEPTH(3), .LOAD_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .flush(flush), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_wen(id_wen), .id_waddr(id_waddr), .id_is_load(id_is_load),
    .exe_rs_data(exe_rs_data), .exe_rt_data(exe_rt_data), .slot_data(slot_data),
    .stall(l1_stall), .fwd_a_sel(l1_asel), .fwd_b_sel(l1_bsel), .exe_opa(l1_opa),
    .exe_opb(l1_opb), .stall_cnt(l1_cnt), .hazard_err(l1_err));

  fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .FWD_DEPTH(3), .LOAD_LAT(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .flush(flush), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_wen(id_wen), .id_waddr(id_waddr), .id_is_load(id_is_load),
    .exe_rs_data(exe_rs_data), .exe_rt_data(exe_rt_data), .slot_data(slot_data),
    .stall(l2_stall), .fwd_a_sel(l2_asel), .fwd_b_sel(l2_bsel), .exe_opa(l2_opa),
    .exe_opb(l2_opb), .stall_cnt(l2_cnt), .hazard_err(l2_err));

  // Advance one full cycle: inputs change and outputs are sampled around the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic ru, input logic tu,
                        input logic we, input logic [4:0] wa, input logic ld);
    id_valid = 1'b1; id_rs_addr = rs; id_rt_addr = rt; id_rs_used = ru; id_rt_used = tu;
    id_wen = we; id_waddr = wa; id_is_load = ld;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs_addr = '0; id_rt_addr = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_wen = 1'b0; id_waddr = '0; id_is_load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pipe_en = 1'b1; flush = 1'b0; idle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(); #1;
    checks++; if (l1_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%0b exp=0", l1_stall); end
    checks++; if (l1_asel !== 2'd0 || l1_bsel !== 2'd0) begin failures++; $display("[TB] FAIL reset_sel got=%0d/%0d exp=0/0", l1_asel, l1_bsel); end
    checks++; if (l1_opa !== 32'hAAAA_0001 || l1_opb !== 32'hBBBB_0002) begin failures++; $display("[TB] FAIL reset_ops got=%h/%h exp=aaaa0001/bbbb0002", l1_opa, l1_opb); end
    checks++; if (l1_cnt !== 32'd0 || l1_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_cnt_err got=%0d/%0b exp=0/0", l1_cnt, l1_err); end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    slot_data = {32'h0000_0333, 32'h0000_0222, 32'h0000_0005};
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    tick();
    set_id(5'd3, 5'd6, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); #1;
    checks++; if (l1_stall !== 1'b0) begin failures++; $display("[TB] FAIL alu_nostall got=%0b exp=0", l1_stall); end
    tick(); idle(); #1;
    checks++; if (l1_asel !== 2'd1 || l1_opa !== 32'h0000_0005) begin failures++; $display("[TB] FAIL alu_fwd_a got=%0d/%h exp=1/00000005", l1_asel, l1_opa); end
    checks++; if (l1_bsel !== 2'd0 || l1_opb !== 32'hBBBB_0002) begin failures++; $display("[TB] FAIL alu_b_regfile got=%0d/%h exp=0/bbbb0002", l1_bsel, l1_opb); end
  endtask

  task automatic test_load_use();
    do_reset();
    slot_data = {32'h0000_0333, 32'h0000_0077, 32'h0000_0011};
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1);
    tick();
    set_id(5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0); #1;
    checks++; if (l1_stall !== 1'b1) begin failures++; $display("[TB] FAIL lu_stall got=%0b exp=1", l1_stall); end
    tick(); #1;
    checks++; if (l1_stall !== 1'b0 || l1_cnt !== 32'd1) begin failures++; $display("[TB] FAIL lu_release got=%0b/%0d exp=0/1", l1_stall, l1_cnt); end
    tick(); idle(); #1;
    checks++; if (l1_asel !== 2'd2 || l1_opa !== 32'h0000_0077) begin failures++; $display("[TB] FAIL lu_fwd got=%0d/%h exp=2/00000077", l1_asel, l1_opa); end
    tick(); #1;
    checks++; if (l1_err !== 1'b0 || l1_cnt !== 32'd1) begin failures++; $display("[TB] FAIL lu_err_cnt got=%0b/%0d exp=0/1", l1_err, l1_cnt); end
  endtask

  task automatic test_load_lat2();
    do_reset();
    slot_data = {32'h0000_0099, 32'h0000_0022, 32'h0000_0011};
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1);
    tick();
    set_id(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0); #1;
    checks++; if (l2_stall !== 1'b1) begin failures++; $display("[TB] FAIL l2_stall1 got=%0b exp=1", l2_stall); end
    tick(); #1;
    checks++; if (l2_stall !== 1'b1) begin failures++; $display("[TB] FAIL l2_stall2 got=%0b exp=1", l2_stall); end
    tick(); #1;
    checks++; if (l2_stall !== 1'b0 || l2_cnt !== 32'd2) begin failures++; $display("[TB] FAIL l2_release got=%0b/%0d exp=0/2", l2_stall, l2_cnt); end
    tick(); idle(); #1;
    checks++; if (l2_asel !== 2'd3 || l2_opa !== 32'h0000_0099) begin failures++; $display("[TB] FAIL l2_fwd got=%0d/%h exp=3/00000099", l2_asel, l2_opa); end
    tick(); #1;
    checks++; if (l2_err !== 1'b0) begin failures++; $display("[TB] FAIL l2_err got=%0b exp=0", l2_err); end
    // register 0: a load or ALU write to $0 never stalls and never forwards
    do_reset();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1);
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0); #1;
    checks++; if (l2_stall !== 1'b0) begin failures++; $display("[TB] FAIL zero_nostall got=%0b exp=0", l2_stall); end
    tick(); idle(); #1;
    checks++; if (l2_asel !== 2'd0 || l2_bsel !== 2'd0 || l2_opa !== 32'hAAAA_0001) begin failures++; $display("[TB] FAIL zero_nofwd got=%0d/%0d/%h exp=0/0/aaaa0001", l2_asel, l2_bsel, l2_opa); end
  endtask

  task automatic test_shadow();
    do_reset();
    slot_data = {32'h0000_0003, 32'h0000_0001, 32'h0000_0002};
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0); tick();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0); tick();
    set_id(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0); tick();
    idle(); #1;
    checks++; if (l1_asel !== 2'd1 || l1_opa !== 32'h0000_0002) begin failures++; $display("[TB] FAIL shadow_fwd got=%0d/%h exp=1/00000002", l1_asel, l1_opa); end
    // older load shadowed by a younger ALU write to the same register must not stall
    do_reset();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1); tick();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0); tick();
    set_id(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0); #1;
    checks++; if (l2_stall !== 1'b0) begin failures++; $display("[TB] FAIL shadow_load got=%0b exp=0", l2_stall); end
  endtask

  task automatic test_flush_freeze();
    do_reset();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1); tick();
    set_id(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0); flush = 1'b1; #1;
    checks++; if (l1_stall !== 1'b0) begin failures++; $display("[TB] FAIL flush_stall got=%0b exp=0", l1_stall); end
    tick(); flush = 1'b0; #1;
    checks++; if (l1_stall !== 1'b0 || l1_cnt !== 32'd0) begin failures++; $display("[TB] FAIL flush_bubble got=%0b/%0d exp=0/0", l1_stall, l1_cnt); end
    tick(); idle(); #1;
    checks++; if (l1_asel !== 2'd0 || l1_opa !== 32'hAAAA_0001) begin failures++; $display("[TB] FAIL flush_killed got=%0d/%h exp=0/aaaa0001", l1_asel, l1_opa); end
    // frozen pipeline keeps the stall asserted without counting it
    do_reset();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1); tick();
    set_id(5'd0, 5'd2, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0); pipe_en = 1'b0;
    tick(); tick(); #1;
    checks++; if (l1_stall !== 1'b1 || l1_cnt !== 32'd0) begin failures++; $display("[TB] FAIL freeze got=%0b/%0d exp=1/0", l1_stall, l1_cnt); end
    pipe_en = 1'b1; tick(); #1;
    checks++; if (l1_stall !== 1'b0 || l1_cnt !== 32'd1) begin failures++; $display("[TB] FAIL unfreeze got=%0b/%0d exp=0/1", l1_stall, l1_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1); tick();
    set_id(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0); #1;
    checks++; if (l1_stall !== 1'b1) begin failures++; $display("[TB] FAIL rms_pre got=%0b exp=1", l1_stall); end
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    checks++; if (l1_stall !== 1'b0 || l1_cnt !== 32'd0 || l1_err !== 1'b0) begin failures++; $display("[TB] FAIL rms_post got=%0b/%0d/%0b exp=0/0/0", l1_stall, l1_cnt, l1_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    slot_data = {32'h0000_0A0A, 32'h0000_0B0B, 32'h0000_0C0C};
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0); tick();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd11, 1'b0); tick();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0); tick();
    set_id(5'd11, 5'd10, 1'b1, 1'b1, 1'b1, 5'd13, 1'b0); #1;
    checks++; if (l1_stall !== 1'b0) begin failures++; $display("[TB] FAIL b2b_stall got=%0b exp=0", l1_stall); end
    tick(); idle(); #1;
    checks++; if (l1_asel !== 2'd2 || l1_opa !== 32'h0000_0B0B) begin failures++; $display("[TB] FAIL b2b_a got=%0d/%h exp=2/00000b0b", l1_asel, l1_opa); end
    checks++; if (l1_bsel !== 2'd3 || l1_opb !== 32'h0000_0A0A) begin failures++; $display("[TB] FAIL b2b_b got=%0d/%h exp=3/00000a0a", l1_bsel, l1_opb); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    rst_n = 1'b0; pipe_en = 1'b1; flush = 1'b0; idle();
    exe_rs_data = 32'hAAAA_0001;
    exe_rt_data = 32'hBBBB_0002;
    slot_data   = '0;
    @(negedge clk);
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_load_lat2();
    test_shadow();
    test_flush_freeze();
    test_reset_mid_stall();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
